// File: rtl/ysyx_22051013_mul_issue_if.sv
// Handshake bundle between the EX-stage multiply issuer and the
// pipelined Booth/Wallace multiplier.
//   master (issuer)    : drives mul_valid, mul_flush, mul_signed, mulw,
//                        mult_op1, mult_op2; receives mul_ready,
//                        out_valid, result_hi, result_lo.
//   slave  (multiplier): the mirror image.
interface ysyx_22051013_mul_issue_if #(
    parameter int XLEN = 64
);
    logic            mul_valid;
    logic            mul_flush;
    logic [1:0]      mul_signed;   // bit0 = op1 signed, bit1 = op2 signed
    logic            mulw;
    logic [XLEN-1:0] mult_op1;
    logic [XLEN-1:0] mult_op2;
    logic            mul_ready;
    logic            out_valid;
    logic [XLEN-1:0] result_hi;
    logic [XLEN-1:0] result_lo;

    modport master (
        output mul_valid, mul_flush, mul_signed, mulw, mult_op1, mult_op2,
        input  mul_ready, out_valid, result_hi, result_lo
    );

    modport slave (
        input  mul_valid, mul_flush, mul_signed, mulw, mult_op1, mult_op2,
        output mul_ready, out_valid, result_hi, result_lo
    );
endinterface

// File: rtl/ysyx_22051013_mul_issue.sv
// EX-stage initiator for the pipelined multiplier.
// Decodes RV64M multiply ops (0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 MULW,
// 5-7 behave as MUL), captures operands, issues a one-cycle mul_valid,
// waits for out_valid, then holds the selected/sign-extended result until
// MEM accepts it. EX is stalled while a multiply is outstanding.
// Ports:
//   clk, rst (async, active-low)
//   ex_valid, ex_is_mul, ex_mul_op, ex_op1, ex_op2 : request from EX
//   flush      : pipeline flush, aborts any state and is passed straight
//                through as mul_flush
//   down_ready : MEM accepts the result
//   ex_stall, res_valid, res : status/result towards the pipeline
//   mul        : multiplier handshake (master modport)
// Optional build macro YSYX_22051013_MUL_FUSE_EN: caches the last 128-bit
// product so a repeated multiply on the same operands skips the multiplier.
module ysyx_22051013_mul_issue #(
    parameter int XLEN = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ex_valid,
    input  logic                          ex_is_mul,
    input  logic [2:0]                    ex_mul_op,
    input  logic [XLEN-1:0]               ex_op1,
    input  logic [XLEN-1:0]               ex_op2,
    input  logic                          flush,
    input  logic                          down_ready,
    output logic                          ex_stall,
    output logic                          res_valid,
    output logic [XLEN-1:0]               res,
    ysyx_22051013_mul_issue_if.master     mul
);
    localparam int HALF = XLEN / 2;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t            state;
    logic [XLEN-1:0]   op1_q, op2_q;
    logic [2:0]        op_q;
    logic [1:0]        sgn_q;
    logic              mulw_q;
    logic              mul_valid_q;
    logic              res_valid_q;
    logic [2*XLEN-1:0] prod_q;

    logic              req;
    logic [1:0]        new_sgn;
    logic              new_w;
    logic              hit;
    logic [XLEN-1:0]   sel;

    assign req = ex_valid & ex_is_mul;

    // Signedness/width of the incoming op; reserved codes behave as MUL.
    always_comb begin
        new_sgn = 2'b11;
        new_w   = 1'b0;
        case (ex_mul_op)
            3'd2:    new_sgn = 2'b01;
            3'd3:    new_sgn = 2'b00;
            3'd4:    new_w   = 1'b1;
            default: ;
        endcase
    end

`ifdef YSYX_22051013_MUL_FUSE_EN
    logic              c_vld;
    logic [XLEN-1:0]   c_op1, c_op2;
    logic [1:0]        c_sgn;
    logic [2*XLEN-1:0] c_prod;
    logic              new_is_mul;

    assign new_is_mul = (ex_mul_op == 3'd0) | (ex_mul_op >= 3'd5);
    // The cache never holds a MULW product, so only the new op is checked.
    // MUL needs only the low half, which is identical for any signedness.
    assign hit = c_vld & (ex_op1 == c_op1) & (ex_op2 == c_op2) & ~new_w
               & (new_is_mul | (c_sgn == new_sgn));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_vld  <= 1'b0;
            c_op1  <= '0;
            c_op2  <= '0;
            c_sgn  <= 2'b00;
            c_prod <= '0;
        end else if (flush) begin
            c_vld <= 1'b0;
        end else if (state == IDLE && req && new_w) begin
            c_vld <= 1'b0;
        end else if (state == WAIT && mul.out_valid) begin
            if (mulw_q) begin
                c_vld <= 1'b0;
            end else begin
                c_vld  <= 1'b1;
                c_op1  <= op1_q;
                c_op2  <= op2_q;
                c_sgn  <= sgn_q;
                c_prod <= {mul.result_hi, mul.result_lo};
            end
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            op1_q       <= '0;
            op2_q       <= '0;
            op_q        <= 3'd0;
            sgn_q       <= 2'b00;
            mulw_q      <= 1'b0;
            mul_valid_q <= 1'b0;
            res_valid_q <= 1'b0;
            prod_q      <= '0;
        end else if (flush) begin
            state       <= IDLE;
            mul_valid_q <= 1'b0;
            res_valid_q <= 1'b0;
            prod_q      <= '0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    op1_q  <= ex_op1;
                    op2_q  <= ex_op2;
                    op_q   <= ex_mul_op;
                    sgn_q  <= new_sgn;
                    mulw_q <= new_w;
`ifdef YSYX_22051013_MUL_FUSE_EN
                    if (hit) begin
                        prod_q      <= c_prod;
                        res_valid_q <= 1'b1;
                        state       <= DONE;
                    end else
`endif
                    begin
                        mul_valid_q <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    mul_valid_q <= 1'b0;
                    state       <= WAIT;
                end
                WAIT: if (mul.out_valid) begin
                    prod_q      <= {mul.result_hi, mul.result_lo};
                    res_valid_q <= 1'b1;
                    state       <= DONE;
                end
                DONE: if (down_ready) begin
                    res_valid_q <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        case (op_q)
            3'd1, 3'd2, 3'd3: sel = prod_q[2*XLEN-1:XLEN];
            3'd4:             sel = {{HALF{prod_q[HALF-1]}}, prod_q[HALF-1:0]};
            default:          sel = prod_q[XLEN-1:0];
        endcase
    end

    assign res_valid      = res_valid_q;
    assign res            = res_valid_q ? sel : '0;
    assign ex_stall       = req & ~((state == DONE) & down_ready);
    assign mul.mul_valid  = mul_valid_q;
    assign mul.mul_flush  = flush;
    assign mul.mul_signed = sgn_q;
    assign mul.mulw       = mulw_q;
    assign mul.mult_op1   = op1_q;
    assign mul.mult_op2   = op2_q;

    // A result handed over while waiting must come with the done flag.
    mul_ready_chk: assert property (@(posedge clk) disable iff (!rst)
        (state == WAIT && mul.out_valid) |-> mul.mul_ready);

    // hit is only consulted when the result cache is built in.
    logic unused_hit;
    assign unused_hit = hit;
endmodule

// File: tb/tb_ysyx_22051013_mul_issue.sv
module tb_ysyx_22051013_mul_issue;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ex_valid = 1'b0, ex_is_mul = 1'b0, flush = 1'b0, down_ready = 1'b0;
    logic [2:0]  ex_mul_op = 3'd0;
    logic [63:0] ex_op1 = '0, ex_op2 = '0;
    logic        ex_stall, res_valid;
    logic [63:0] res;

    int nerr = 0;
    int nchk = 0;

    always #5 clk = ~clk;

    ysyx_22051013_mul_issue_if #(.XLEN(64)) mif ();

    ysyx_22051013_mul_issue #(.XLEN(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .ex_valid   (ex_valid),
        .ex_is_mul  (ex_is_mul),
        .ex_mul_op  (ex_mul_op),
        .ex_op1     (ex_op1),
        .ex_op2     (ex_op2),
        .flush      (flush),
        .down_ready (down_ready),
        .ex_stall   (ex_stall),
        .res_valid  (res_valid),
        .res        (res),
        .mul        (mif.master)
    );

    // Full-width product as a plain arithmetic reference.
    function automatic logic [127:0] prod128(input logic [63:0] a, input logic [63:0] b,
                                             input logic [1:0] sgn);
        logic [127:0] ax, bx;
        ax = sgn[0] ? {{64{a[63]}}, a} : {64'd0, a};
        bx = sgn[1] ? {{64{b[63]}}, b} : {64'd0, b};
        return ax * bx;
    endfunction

    // Behavioural multiplier: answers lat cycles after mul_valid.
    int           lat = 1;
    int           pulses = 0;
    int           cnt;
    logic         pend;
    logic [127:0] sp;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend           <= 1'b0;
            cnt            <= 0;
            mif.out_valid  <= 1'b0;
            mif.mul_ready  <= 1'b0;
            mif.result_hi  <= '0;
            mif.result_lo  <= '0;
        end else begin
            mif.out_valid <= 1'b0;
            mif.mul_ready <= 1'b0;
            if (mif.mul_flush) begin
                pend <= 1'b0;
            end else if (mif.mul_valid) begin
                pend   <= 1'b1;
                cnt    <= lat;
                sp     <= prod128(mif.mult_op1, mif.mult_op2, mif.mul_signed);
                pulses <= pulses + 1;
            end else if (pend) begin
                if (cnt <= 1) begin
                    mif.out_valid <= 1'b1;
                    mif.mul_ready <= 1'b1;
                    mif.result_hi <= sp[127:64];
                    mif.result_lo <= sp[63:0];
                    pend          <= 1'b0;
                end else begin
                    cnt <= cnt - 1;
                end
            end
        end
    end

    // ISA-level meaning of each op.
    function automatic logic [1:0] isa_sgn(input logic [2:0] op);
        case (op)
            3'd2:    return 2'b01;
            3'd3:    return 2'b00;
            default: return 2'b11;
        endcase
    endfunction

    function automatic logic [63:0] isa_res(input logic [2:0] op, input logic [63:0] a,
                                            input logic [63:0] b);
        logic [127:0] p;
        logic [63:0]  w;
        p = prod128(a, b, isa_sgn(op));
        w = a * b;
        case (op)
            3'd1, 3'd2, 3'd3: return p[127:64];
            3'd4:             return {{32{w[31]}}, w[31:0]};
            default:          return p[63:0];
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model of the fuse cache (only consulted when built in).
    logic        m_vld = 1'b0;
    logic [63:0] m_a, m_b;
    logic [1:0]  m_sgn;

    task automatic run_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                          input int hold);
        int          n;
        int          p0;
        logic        done;
        logic        hit;
        logic [2:0]  eop;
        logic [63:0] exp, held;
        eop = (op >= 3'd5) ? 3'd0 : op;
        hit = 1'b0;
`ifdef YSYX_22051013_MUL_FUSE_EN
        hit = m_vld && a == m_a && b == m_b && op != 3'd4 &&
              (eop == 3'd0 || m_sgn == isa_sgn(op));
`endif
        exp = isa_res(op, a, b);
        p0  = pulses;
        @(negedge clk);
        ex_valid = 1'b1; ex_is_mul = 1'b1; ex_mul_op = op;
        ex_op1 = a; ex_op2 = b; down_ready = 1'b0;
        #1 check("stall_on_request", ex_stall, 1);
        n = 0; done = 1'b0;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (!hit && n == 1) begin
                check("mul_valid_issue", mif.mul_valid, 1);
                check("mul_signed", mif.mul_signed, isa_sgn(op));
                check("mulw_issue", mif.mulw, op == 3'd4);
                check("mult_op1", mif.mult_op1, a);
                check("mult_op2", mif.mult_op2, b);
            end
            if (!hit && n == 2) begin
                check("mul_valid_one_cycle", mif.mul_valid, 0);
                check("mulw_wait", mif.mulw, op == 3'd4);
            end
            if (res_valid) done = 1'b1;
        end
        check("res_valid_in_time", done, 1);
        check("latency", n, hit ? 1 : lat + 3);
        check("res", res, exp);
        check("issue_pulses", pulses - p0, hit ? 0 : 1);
        held = res;
        for (int h = 0; h < hold; h++) begin
            check("stall_in_done", ex_stall, 1);
            @(posedge clk); #1;
            check("hold_res_valid", res_valid, 1);
            check("hold_res", res, held);
        end
        @(negedge clk);
        down_ready = 1'b1;
        #1 check("stall_release", ex_stall, 0);
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_is_mul = 1'b0; down_ready = 1'b0;
        check("res_valid_after", res_valid, 0);
        check("res_zero_after", res, 0);
        if (op == 3'd4) m_vld = 1'b0;
        else if (!hit) begin
            m_vld = 1'b1; m_a = a; m_b = b; m_sgn = isa_sgn(op);
        end
    endtask

    task automatic pulse_flush();
        @(negedge clk);
        flush = 1'b1;
        #1 check("mul_flush_follows", mif.mul_flush, 1);
        @(posedge clk); #1;
        flush = 1'b0; ex_valid = 1'b0; ex_is_mul = 1'b0;
        m_vld = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic seen;
        logic [63:0] a, b;
        // Reset state
        #12;
        check("rst_res_valid", res_valid, 0);
        check("rst_res", res, 0);
        check("rst_mul_valid", mif.mul_valid, 0);
        check("rst_mul_signed", mif.mul_signed, 0);
        check("rst_mulw", mif.mulw, 0);
        check("rst_mult_op1", mif.mult_op1, 0);
        check("rst_ex_stall", ex_stall, 0);
        @(negedge clk); rst = 1'b1;

        // Directed cases
        lat = 1;
        run_op(3'd0, 64'd3, 64'd5, 0);
        run_op(3'd1, '1, '1, 0);
        run_op(3'd3, '1, '1, 0);
        run_op(3'd2, '1, 64'd2, 0);
        lat = 3;
        run_op(3'd4, 64'h7FFF_FFFF, 64'd2, 1);

        // Flush while waiting on the multiplier
        lat = 5;
        @(negedge clk);
        ex_valid = 1'b1; ex_is_mul = 1'b1; ex_mul_op = 3'd0;
        ex_op1 = 64'd9; ex_op2 = 64'd9;
        @(posedge clk); @(posedge clk);
        pulse_flush();
        check("flush_no_res_valid", res_valid, 0);
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (res_valid) seen = 1'b1;
        end
        check("flush_drops_result", seen, 0);
        lat = 2;
        run_op(3'd0, 64'd7, 64'd6, 0);

        // Flush with a request in IDLE: not captured
        @(negedge clk);
        ex_valid = 1'b1; ex_is_mul = 1'b1; ex_mul_op = 3'd0; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; ex_valid = 1'b0; ex_is_mul = 1'b0; m_vld = 1'b0;
        @(posedge clk); #1;
        check("flush_idle_no_issue", mif.mul_valid, 0);

        // Backpressure from MEM for three cycles
        lat = 1;
        run_op(3'd0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9, 3);

        // Reset in the middle of a MULW
        @(negedge clk);
        ex_valid = 1'b1; ex_is_mul = 1'b1; ex_mul_op = 3'd4;
        ex_op1 = 64'd5; ex_op2 = 64'd5;
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check("midrst_mul_valid", mif.mul_valid, 0);
        check("midrst_mulw", mif.mulw, 0);
        check("midrst_res_valid", res_valid, 0);
        ex_valid = 1'b0; ex_is_mul = 1'b0; m_vld = 1'b0;
        @(negedge clk); rst = 1'b1;

`ifdef YSYX_22051013_MUL_FUSE_EN
        run_op(3'd3, 64'h1_0000_0001, 64'd3, 0);
        run_op(3'd0, 64'h1_0000_0001, 64'd3, 0);
        check("fuse_res", isa_res(3'd0, 64'h1_0000_0001, 64'd3), 64'h3_0000_0003);
        run_op(3'd3, 64'h1_0000_0001, 64'd3, 0);
        pulse_flush();
        run_op(3'd0, 64'h1_0000_0001, 64'd3, 0);
`endif

        // Randomized ops
        for (int i = 0; i < 24; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if (i % 4 == 1) a = 64'($urandom_range(0, 100));
            if (i % 5 == 2) b = -64'($urandom_range(1, 100));
            lat = $urandom_range(1, 4);
            run_op(3'($urandom_range(0, 7)), a, b, $urandom_range(0, 2));
            if (i % 6 == 3) run_op(3'($urandom_range(0, 3)), a, b, 0);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/ysyx_22051013_mul_issue.md
Name: ysyx_22051013_mul_issue

Overview:
EX-stage initiator for the pipelined Booth/Wallace multiplier. Decodes RV64M multiply ops (MUL, MULH, MULHSU, MULHU, MULW) and captures operands. Drives the multiplier's mul_valid/flush/mul_signed/mulw handshake, waits for out_valid, selects and sign-extends the result, and holds it until MEM accepts. Stalls EX while an op is outstanding.

Parameters:
XLEN, 64, operand/result width; only 64 is supported.

Ports:
clk  in  1  clock.
rst  in  1  asynchronous reset, active-low (0 = reset).
ex_valid  in  1  EX holds a valid instruction.
ex_is_mul  in  1  instruction is a multiply.
ex_mul_op  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 MULW; 5-7 reserved (treated as MUL).
ex_op1  in  XLEN  rs1 value.
ex_op2  in  XLEN  rs2 value.
flush  in  1  pipeline flush.
down_ready  in  1  MEM accepts the result this cycle.
ex_stall  out  1  hold EX stage.
res_valid  out  1  res is valid.
res  out  XLEN  rd write value.
mul_valid  out  1  start pulse to multiplier.
mul_flush  out  1  flush to multiplier.
mul_signed  out  2  bit0 = op1 signed, bit1 = op2 signed.
mulw  out  1  32-bit op.
mult_op1  out  XLEN  operand 1, registered.
mult_op2  out  XLEN  operand 2, registered.
mul_ready  in  1  multiplier ready/done.
out_valid  in  1  multiplier result valid.
result_hi  in  XLEN  product [127:64].
result_lo  in  XLEN  product [63:0].

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; operand/op registers cleared; cache invalid.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: if ex_valid & ex_is_mul & ~flush, capture ex_op1/ex_op2/ex_mul_op, then go to ISSUE.
- ISSUE: mul_valid=1 for exactly one cycle, then go to WAIT.
- WAIT: on out_valid, latch result_hi/result_lo into a 128-bit register, then go to DONE.
- DONE: res_valid=1. On down_ready go to IDLE; a new request is accepted the next cycle, never the same cycle.
- mult_op1/op2/mul_signed/mulw are driven from the captured registers and are stable from ISSUE through WAIT.
- Signedness mapping: MUL 11, MULH 11, MULHSU 01, MULHU 00, MULW 11 with mulw=1; mulw=0 for every other op.
- Result select:
  - MUL: lo[63:0].
  - MULH/MULHSU/MULHU: hi[63:0].
  - MULW: {32{lo[31]}, lo[31:0]}.
- res is 0 whenever res_valid=0.
- ex_stall = ex_valid & ex_is_mul & ~(DONE & down_ready).
  - Latency: capture at T0, mul_valid at T1, DONE one cycle after out_valid.
- flush in any state:
  - mul_flush=flush in the same cycle (combinational).
  - Next state IDLE; latched result discarded; res_valid=0 from the next cycle.
  - flush in the same cycle as out_valid: result dropped.
  - flush in IDLE with a request: request not captured.
- out_valid outside WAIT is ignored.
- mul_ready is used only as an assertion check: mul_ready must accompany out_valid in WAIT.
- Reset mid-operation: immediate return to IDLE. The multiplier is reset by the same rst, so no mul_flush pulse is needed.

Optional Feature:
Macro: YSYX_22051013_MUL_FUSE_EN.
- With it: the last completed 128-bit product is cached with op1, op2, signedness and a valid bit.
- Hit condition, checked on capture in IDLE:
  - cache valid;
  - op1 and op2 equal;
  - neither old nor new op is MULW;
  - new op is MUL, or cached signedness equals new signedness.
- On a hit: skip ISSUE/WAIT, no mul_valid, go IDLE -> DONE, res_valid one cycle after capture.
- Cache is invalidated on reset, on flush, and on any MULW.
- Without it: no cache registers; every op is issued.

Test Plan:
- MUL 3 x 5 -> one mul_valid pulse; res=15 with res_valid the cycle after out_valid; ex_stall high until DONE & down_ready.
- Sign variants, op1=0xFFFF_FFFF_FFFF_FFFF:
  - MULH with op2=-1 -> res=0.
  - MULHU with op2=-1 -> res=0xFFFF_FFFF_FFFF_FFFE.
  - MULHSU with op2=2 -> res=0xFFFF_FFFF_FFFF_FFFF; mul_signed=01.
- MULW 0x7FFF_FFFF x 2 -> res=0xFFFF_FFFF_FFFF_FFFE; mulw=1 during ISSUE/WAIT.
- flush asserted in WAIT -> mul_flush=1 that cycle; IDLE next; no res_valid. A following MUL 7 x 6 returns 42.
- down_ready held low 3 cycles in DONE -> res and res_valid stable; released on the 4th cycle; ex_stall drops in the same cycle.
- FUSE_EN: MULHU a,b then MUL a,b (a=0x1_0000_0001, b=3):
  - second op issues no mul_valid;
  - res=0x3_0000_0003 one cycle after capture;
  - a flush between the two ops forces a normal issue.
